// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor, bundled.
// The slave modport is the adaptor. The master modport is the environment that drives the cache and memory.
interface cacheline_adaptor_if #(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;

    logic [LINE_WIDTH-1:0] line_i;
    logic [LINE_WIDTH-1:0] line_o;
    logic [ADDR_WIDTH-1:0] address_i;
    logic                  read_i;
    logic                  write_i;
    logic                  resp_o;
    logic [BEAT_WIDTH-1:0] burst_i;
    logic [BEAT_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0] address_o;
    logic                  read_o;
    logic                  write_o;
    logic                  resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits a cacheline fill or write-back into a BEATS-long burst on the memory bus.
// When the burst completes, the adaptor sends the cache a one-cycle resp_o.
module cacheline_adaptor #(
    parameter int BEAT_WIDTH  = 64,
    parameter int BEATS       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);
    localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nx;
    logic                  last_beat;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign count_nx  = count + 1'b1;
    assign last_beat = (count == CNT_W'(BEATS - 1));
    assign line_addr = {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // line_buf holds the latched write-back line or the fill being assembled.
    // line_o is only updated on the final read beat, so it holds steady until the next fill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            line_buf      <= '0;
            bus.line_o    <= '0;
            bus.resp_o    <= 1'b0;
            bus.read_o    <= 1'b0;
            bus.write_o   <= 1'b0;
            bus.burst_o   <= '0;
            bus.address_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read_i) begin
                        state         <= RD;
                        bus.read_o    <= 1'b1;
                        bus.address_o <= line_addr;
                    end else if (bus.write_i) begin
                        state         <= WR;
                        bus.write_o   <= 1'b1;
                        bus.address_o <= line_addr;
                        line_buf      <= bus.line_i;
                        bus.burst_o   <= bus.line_i[BEAT_WIDTH-1:0];
                    end
                end
                RD: begin
                    if (bus.resp_i) begin
                        line_buf[count*BEAT_WIDTH +: BEAT_WIDTH] <= bus.burst_i;
                        if (last_beat) begin
                            state      <= DONE;
                            count      <= '0;
                            bus.read_o <= 1'b0;
                            bus.resp_o <= 1'b1;
                            bus.line_o <= {bus.burst_i, line_buf[LINE_WIDTH-BEAT_WIDTH-1:0]};
                        end else begin
                            count <= count_nx;
                        end
                    end
                end
                WR: begin
                    if (bus.resp_i) begin
                        if (last_beat) begin
                            state       <= DONE;
                            count       <= '0;
                            bus.write_o <= 1'b0;
                            bus.resp_o  <= 1'b1;
                            bus.burst_o <= '0;
                        end else begin
                            count       <= count_nx;
                            bus.burst_o <= line_buf[count_nx*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.resp_o    <= 1'b0;
                    bus.address_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, write-backs, stalls, arbitration, reset and stray strobes.
module tb_cacheline_adaptor;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full fill with consecutive resp_i; beat k carries seed+k.
    task automatic run_read(input string tag, input logic [31:0] addr, input logic [63:0] seed);
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        exp_addr = {addr[31:5], 5'b0};
        bus.address_i = addr;
        bus.read_i    = 1'b1;
        step();
        bus.read_i    = 1'b0;
        chk({tag, "_read_o"}, 256'(bus.read_o), 256'(1));
        chk({tag, "_addr"}, 256'(bus.address_o), 256'(exp_addr));
        for (int k = 0; k < 4; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = seed + 64'(k);
            exp_line[k*64 +: 64] = seed + 64'(k);
            step();
        end
        bus.resp_i = 1'b0;
        chk({tag, "_resp"}, 256'(bus.resp_o), 256'(1));
        chk({tag, "_line"}, bus.line_o, exp_line);
        step();
        chk({tag, "_resp_end"}, 256'(bus.resp_o), 256'(0));
    endtask

    logic [63:0]  rb [4];
    logic [63:0]  wb [4];
    logic [255:0] line_a;
    logic [255:0] line_w;
    logic [255:0] line_s;
    int           pat [7];
    int           nbeat;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        step();
        step();
        chk("rst_read_o",  256'(bus.read_o),    256'(0));
        chk("rst_write_o", 256'(bus.write_o),   256'(0));
        chk("rst_resp_o",  256'(bus.resp_o),    256'(0));
        chk("rst_addr",    256'(bus.address_o), 256'(0));
        chk("rst_burst",   256'(bus.burst_o),   256'(0));
        chk("rst_line",    bus.line_o,          256'(0));
        rst = 1'b0;

        // Basic read, with address_i disturbed mid-burst.
        rb[0] = 64'h1111_1111_1111_1111;
        rb[1] = 64'h2222_2222_2222_2222;
        rb[2] = 64'h3333_3333_3333_3333;
        rb[3] = 64'h4444_4444_4444_4444;
        line_a = {rb[3], rb[2], rb[1], rb[0]};
        bus.address_i = 32'h0000_1234;
        bus.read_i    = 1'b1;
        step();
        bus.read_i    = 1'b0;
        bus.address_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            chk("rd_read_o", 256'(bus.read_o), 256'(1));
            chk("rd_addr", 256'(bus.address_o), 256'(32'h0000_1220));
            chk("rd_no_resp", 256'(bus.resp_o), 256'(0));
            bus.resp_i  = 1'b1;
            bus.burst_i = rb[k];
            step();
        end
        bus.resp_i = 1'b0;
        chk("rd_resp",   256'(bus.resp_o), 256'(1));
        chk("rd_read_lo", 256'(bus.read_o), 256'(0));
        chk("rd_line",   bus.line_o, line_a);
        step();
        chk("rd_resp_pulse", 256'(bus.resp_o), 256'(0));
        chk("rd_idle_addr", 256'(bus.address_o), 256'(0));
        chk("rd_line_hold", bus.line_o, line_a);

        // Write-back, with line_i disturbed mid-burst.
        wb[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wb[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        line_w = {wb[3], wb[2], wb[1], wb[0]};
        bus.line_i    = line_w;
        bus.address_i = 32'h8000_00FF;
        bus.write_i   = 1'b1;
        step();
        bus.write_i = 1'b0;
        bus.line_i  = '0;
        for (int k = 0; k < 4; k++) begin
            chk("wr_write_o", 256'(bus.write_o), 256'(1));
            chk("wr_addr", 256'(bus.address_o), 256'(32'h8000_00E0));
            chk("wr_burst", 256'(bus.burst_o), 256'(wb[k]));
            bus.resp_i = 1'b1;
            step();
        end
        bus.resp_i = 1'b0;
        chk("wr_resp",     256'(bus.resp_o),  256'(1));
        chk("wr_write_lo", 256'(bus.write_o), 256'(0));
        chk("wr_line_hold", bus.line_o, line_a);
        step();
        chk("wr_resp_pulse", 256'(bus.resp_o), 256'(0));

        // Stalled read: resp_i pattern 1,0,0,1,0,1,1.
        pat = '{1, 0, 0, 1, 0, 1, 1};
        bus.address_i = 32'h0000_0040;
        bus.read_i    = 1'b1;
        step();
        bus.read_i = 1'b0;
        nbeat = 0;
        for (int j = 0; j < 7; j++) begin
            chk("st_read_o", 256'(bus.read_o), 256'(1));
            chk("st_no_resp", 256'(bus.resp_o), 256'(0));
            bus.resp_i  = pat[j][0];
            bus.burst_i = 64'h5000_0000_0000_0000 + 64'(j);
            if (pat[j] == 1) begin
                line_s[nbeat*64 +: 64] = 64'h5000_0000_0000_0000 + 64'(j);
                nbeat++;
            end
            step();
        end
        bus.resp_i = 1'b0;
        chk("st_resp", 256'(bus.resp_o), 256'(1));
        chk("st_line", bus.line_o, line_s);
        step();
        chk("st_resp_pulse", 256'(bus.resp_o), 256'(0));

        // Read and write requested together: read first, then the pending write.
        bus.address_i = 32'h0000_0080;
        bus.line_i    = line_w;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        step();
        bus.read_i = 1'b0;
        chk("both_read_o",  256'(bus.read_o),  256'(1));
        chk("both_write_o", 256'(bus.write_o), 256'(0));
        for (int k = 0; k < 4; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rb[3-k];
            step();
        end
        bus.resp_i = 1'b0;
        chk("both_resp1", 256'(bus.resp_o), 256'(1));
        chk("both_line", bus.line_o, {rb[0], rb[1], rb[2], rb[3]});
        step();
        chk("both_idle_resp", 256'(bus.resp_o), 256'(0));
        chk("both_idle_write", 256'(bus.write_o), 256'(0));
        step();
        bus.write_i = 1'b0;
        chk("both_write_start", 256'(bus.write_o), 256'(1));
        for (int k = 0; k < 4; k++) begin
            chk("both_burst", 256'(bus.burst_o), 256'(wb[k]));
            chk("both_no_resp", 256'(bus.resp_o), 256'(0));
            bus.resp_i = 1'b1;
            step();
        end
        bus.resp_i = 1'b0;
        chk("both_resp2", 256'(bus.resp_o), 256'(1));
        step();
        chk("both_resp2_pulse", 256'(bus.resp_o), 256'(0));

        // Reset after two beats of a read, then a clean read.
        bus.address_i = 32'h0000_1000;
        bus.read_i    = 1'b1;
        step();
        bus.read_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hDEAD_0000_0000_0000 + 64'(k);
            step();
        end
        bus.resp_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_read_o", 256'(bus.read_o), 256'(0));
        chk("mrst_resp_o", 256'(bus.resp_o), 256'(0));
        chk("mrst_line",   bus.line_o,       256'(0));
        chk("mrst_addr",   256'(bus.address_o), 256'(0));
        run_read("post_rst", 32'h0000_2000, 64'h7000_0000_0000_0000);

        // Stray resp_i in IDLE and DONE.
        bus.resp_i  = 1'b1;
        bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        step();
        chk("stray_idle_read",  256'(bus.read_o),  256'(0));
        chk("stray_idle_write", 256'(bus.write_o), 256'(0));
        chk("stray_idle_resp",  256'(bus.resp_o),  256'(0));
        bus.address_i = 32'h0000_3000;
        bus.read_i    = 1'b1;
        step();
        bus.read_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.burst_i = 64'h9000_0000_0000_0000 + 64'(k);
            step();
        end
        chk("stray_rd_resp", 256'(bus.resp_o), 256'(1));
        chk("stray_rd_line", bus.line_o, {64'h9000_0000_0000_0003, 64'h9000_0000_0000_0002,
                                          64'h9000_0000_0000_0001, 64'h9000_0000_0000_0000});
        step();
        chk("stray_done_resp", 256'(bus.resp_o), 256'(0));
        chk("stray_done_read", 256'(bus.read_o), 256'(0));
        step();
        chk("stray_after_resp", 256'(bus.resp_o), 256'(0));
        bus.resp_i = 1'b0;
        run_read("post_stray", 32'h0000_4010, 64'h6000_0000_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
